// File: rtl/lattice_readout.sv
// Frame readout: scans the lattice, sums the 9 direction distributions per cell and
// streams raster-ordered (hor, vert, density) pixels through a credit-checked FIFO.
module lattice_readout #(
  parameter  int HPIXELS    = 205,
  parameter  int VPIXELS    = 154,
  parameter  int DATA_WIDTH = 9,
  parameter  int RD_LATENCY = 2,
  parameter  int FIFO_DEPTH = 8,
  localparam int HOR_SIZE   = $clog2(HPIXELS),
  localparam int VERT_SIZE  = $clog2(VPIXELS),
  localparam int BRAM_SIZE  = $clog2(HPIXELS * VPIXELS),
  localparam int SUM_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       start_in,
  input  logic [8:0][DATA_WIDTH-1:0] data_in,
  output logic [BRAM_SIZE-1:0]       addr_out,
  output logic [HOR_SIZE-1:0]        hor_out,
  output logic [VERT_SIZE-1:0]       vert_out,
  output logic [SUM_WIDTH-1:0]       density_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       busy_out,
  output logic                       done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [HOR_SIZE-1:0]  HOR_LAST  = HOR_SIZE'(HPIXELS - 1);
  localparam logic [VERT_SIZE-1:0] VERT_LAST = VERT_SIZE'(VPIXELS - 1);
  localparam logic [CNT_W:0]       DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t               state_q;
  logic [BRAM_SIZE-1:0] addr_q, lin_q;
  logic [HOR_SIZE-1:0]  hor_q;
  logic [VERT_SIZE-1:0] vert_q;
  logic                 done_q;

  logic                 tagValid_q [0:RD_LATENCY];
  logic [HOR_SIZE-1:0]  tagHor_q   [0:RD_LATENCY];
  logic [VERT_SIZE-1:0] tagVert_q  [0:RD_LATENCY];

  logic                 sumValid_q;
  logic [SUM_WIDTH-1:0] sum_q;
  logic [HOR_SIZE-1:0]  sumHor_q;
  logic [VERT_SIZE-1:0] sumVert_q;

  logic [HOR_SIZE-1:0]  memHor_q     [0:FIFO_DEPTH-1];
  logic [VERT_SIZE-1:0] memVert_q    [0:FIFO_DEPTH-1];
  logic [SUM_WIDTH-1:0] memDensity_q [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]     count_q, inflight_q;

  logic                 issue, lastCell, push, pop, drainDone;
  logic [CNT_W-1:0]     count_d, inflight_d;
  logic [SUM_WIDTH-1:0] sum_d;

  // A read may only be issued if every outstanding tag is guaranteed a FIFO slot.
  always_comb begin
    issue      = (state_q == SCAN) &&
                 (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C);
    lastCell   = (hor_q == HOR_LAST) && (vert_q == VERT_LAST);
    push       = sumValid_q;
    pop        = (count_q != '0) && ready_in;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
    drainDone  = (state_q == DRAIN) && (inflight_d == '0) && (count_d == '0);
    sum_d      = '0;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + SUM_WIDTH'(data_in[i]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lin_q      <= '0;
      hor_q      <= '0;
      vert_q     <= '0;
      done_q     <= 1'b0;
      for (int k = 0; k <= RD_LATENCY; k++) begin
        tagValid_q[k] <= 1'b0;
        tagHor_q[k]   <= '0;
        tagVert_q[k]  <= '0;
      end
      sumValid_q <= 1'b0;
      sum_q      <= '0;
      sumHor_q   <= '0;
      sumVert_q  <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        memHor_q[j]     <= '0;
        memVert_q[j]    <= '0;
        memDensity_q[j] <= '0;
      end
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q <= SCAN;
            lin_q   <= '0;
            hor_q   <= '0;
            vert_q  <= '0;
          end
        end
        SCAN: begin
          if (issue) begin
            addr_q <= lin_q;
            lin_q  <= lin_q + BRAM_SIZE'(1);
            if (hor_q == HOR_LAST) begin
              hor_q  <= '0;
              vert_q <= vert_q + VERT_SIZE'(1);
            end else begin
              hor_q  <= hor_q + HOR_SIZE'(1);
            end
            if (lastCell) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drainDone) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // The tag travels alongside the fixed BRAM latency so it lines up with data_in.
      tagValid_q[0] <= issue;
      tagHor_q[0]   <= hor_q;
      tagVert_q[0]  <= vert_q;
      for (int k = 1; k <= RD_LATENCY; k++) begin
        tagValid_q[k] <= tagValid_q[k-1];
        tagHor_q[k]   <= tagHor_q[k-1];
        tagVert_q[k]  <= tagVert_q[k-1];
      end

      sumValid_q <= tagValid_q[RD_LATENCY];
      sum_q      <= sum_d;
      sumHor_q   <= tagHor_q[RD_LATENCY];
      sumVert_q  <= tagVert_q[RD_LATENCY];

      if (push) begin
        memHor_q[wrPtr_q]     <= sumHor_q;
        memVert_q[wrPtr_q]    <= sumVert_q;
        memDensity_q[wrPtr_q] <= sum_q;
        wrPtr_q               <= wrPtr_q + PTR_W'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  assign addr_out    = addr_q;
  assign hor_out     = memHor_q[rdPtr_q];
  assign vert_out    = memVert_q[rdPtr_q];
  assign density_out = memDensity_q[rdPtr_q];
  assign valid_out   = (count_q != '0);
  assign busy_out    = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_lattice_readout.sv
// Directed bench for lattice_readout on a 4x3 lattice with a 2-cycle BRAM model
// whose direction i returns address+i (or 511 in saturation mode).
module tb_lattice_readout;

  localparam int HPIXELS    = 4;
  localparam int VPIXELS    = 3;
  localparam int DATA_WIDTH = 9;
  localparam int FIFO_DEPTH = 8;
  localparam int HOR_SIZE   = $clog2(HPIXELS);
  localparam int VERT_SIZE  = $clog2(VPIXELS);
  localparam int BRAM_SIZE  = $clog2(HPIXELS * VPIXELS);
  localparam int SUM_WIDTH  = DATA_WIDTH + 4;

  logic                       clk_in = 1'b0;
  logic                       rst_in = 1'b1;
  logic                       start_in = 1'b0;
  logic [8:0][DATA_WIDTH-1:0] data_in;
  logic [BRAM_SIZE-1:0]       addr_out;
  logic [HOR_SIZE-1:0]        hor_out;
  logic [VERT_SIZE-1:0]       vert_out;
  logic [SUM_WIDTH-1:0]       density_out;
  logic                       valid_out;
  logic                       ready_in = 1'b1;
  logic                       busy_out;
  logic                       done;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   pixIdx = 0;
  int   doneCount = 0;
  int   doneCycle = -1;
  int   lastHs = -1;
  logic checkTiming = 1'b0;
  logic allMax = 1'b0;
  logic overflowSeen = 1'b0;
  logic heldPrev = 1'b0;
  logic [HOR_SIZE-1:0]  prevHor;
  logic [VERT_SIZE-1:0] prevVert;
  logic [SUM_WIDTH-1:0] prevDensity;
  logic [BRAM_SIZE-1:0] addrD1 = '0;
  logic [BRAM_SIZE-1:0] addrD2 = '0;

  lattice_readout #(
    .HPIXELS(HPIXELS), .VPIXELS(VPIXELS), .DATA_WIDTH(DATA_WIDTH),
    .RD_LATENCY(2), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .data_in(data_in),
    .addr_out(addr_out), .hor_out(hor_out), .vert_out(vert_out),
    .density_out(density_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy_out(busy_out), .done(done)
  );

  initial forever #5 clk_in = ~clk_in;

  // Two-cycle BRAM: data seen in cycle c belongs to the address presented in cycle c-2.
  always @(posedge clk_in) begin
    addrD1 <= addr_out;
    addrD2 <= addrD1;
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      data_in[i] = allMax ? 9'd511 : (DATA_WIDTH'(addrD2) + DATA_WIDTH'(i));
    end
  end

  always @(negedge clk_in) begin
    if (dut.sumValid_q && (dut.count_q == FIFO_DEPTH)) overflowSeen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs, check handshakes/holds seen in this cycle, then advance.
  task automatic applyStimulus(input logic s, input logic r, input logic rs);
    start_in = s;
    ready_in = r;
    rst_in   = rs;
    if (heldPrev) begin
      checkOutput("holdValid", 32'(valid_out), 32'd1);
      checkOutput("holdHor", 32'(hor_out), 32'(prevHor));
      checkOutput("holdVert", 32'(vert_out), 32'(prevVert));
      checkOutput("holdDensity", 32'(density_out), 32'(prevDensity));
    end
    heldPrev    = valid_out && !r && !rs;
    prevHor     = hor_out;
    prevVert    = vert_out;
    prevDensity = density_out;
    if (valid_out && r && !rs) begin
      checkOutput("pixHor", 32'(hor_out), 32'(pixIdx % HPIXELS));
      checkOutput("pixVert", 32'(vert_out), 32'(pixIdx / HPIXELS));
      checkOutput("pixDensity", 32'(density_out), allMax ? 32'd4599 : 32'(9 * pixIdx + 36));
      if (checkTiming) checkOutput("pixCycle", cyc, 6 + pixIdx);
      pixIdx++;
      lastHs = cyc;
    end
    if (done) begin
      doneCount++;
      doneCycle = cyc;
    end
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  initial begin
    $display("[TB] lattice_readout directed test, %0dx%0d lattice", HPIXELS, VPIXELS);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    checkOutput("rstValid", 32'(valid_out), 32'd0);
    checkOutput("rstBusy", 32'(busy_out), 32'd0);
    checkOutput("rstAddr", 32'(addr_out), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstHor", 32'(hor_out), 32'd0);
    checkOutput("rstDensity", 32'(density_out), 32'd0);

    // Frame 1: full-rate readout, density = 9*addr + 36.
    cyc = 0; pixIdx = 0; doneCount = 0; doneCycle = -1; checkTiming = 1'b1;
    applyStimulus(1, 1, 0);
    checkOutput("busyScan", 32'(busy_out), 32'd1);
    applyStimulus(0, 1, 0);
    checkOutput("addrFirst", 32'(addr_out), 32'd0);
    applyStimulus(0, 1, 0);
    checkOutput("addrSecond", 32'(addr_out), 32'd1);
    while (cyc < 25) applyStimulus(0, 1, 0);
    checkOutput("f1Pixels", pixIdx, 12);
    checkOutput("f1DoneCount", doneCount, 1);
    checkOutput("f1DoneCycle", doneCycle, 18);
    checkOutput("f1BusyIdle", 32'(busy_out), 32'd0);

    // Frame 2: every distribution at its maximum.
    allMax = 1'b1;
    cyc = 0; pixIdx = 0; doneCount = 0; doneCycle = -1;
    applyStimulus(1, 1, 0);
    while (cyc < 25) applyStimulus(0, 1, 0);
    checkOutput("f2Pixels", pixIdx, 12);
    checkOutput("f2DoneCycle", doneCycle, 18);
    allMax = 1'b0;

    // Frame 3: ready low for cycles 5..20, issue must stall at 8 outstanding cells.
    cyc = 0; pixIdx = 0; doneCount = 0; doneCycle = -1; checkTiming = 1'b0;
    applyStimulus(1, 1, 0);
    while (cyc < 12) applyStimulus(0, (cyc < 5), 0);
    checkOutput("stallAddr12", 32'(addr_out), 32'd7);
    while (cyc < 20) applyStimulus(0, 1'b0, 0);
    checkOutput("stallAddr20", 32'(addr_out), 32'd7);
    checkOutput("stallValid", 32'(valid_out), 32'd1);
    checkOutput("stallHeadHor", 32'(hor_out), 32'd0);
    while (cyc < 45) applyStimulus(0, (cyc > 20), 0);
    checkOutput("f3Pixels", pixIdx, 12);
    checkOutput("f3LastHs", lastHs, 32);
    checkOutput("f3DoneCycle", doneCycle, 33);
    checkOutput("f3DoneCount", doneCount, 1);

    // Frame 4: ready alternating 1,0,1,0 from the start cycle.
    cyc = 0; pixIdx = 0; doneCount = 0; doneCycle = -1;
    applyStimulus(1, 1, 0);
    while (cyc < 45) applyStimulus(0, (cyc % 2 == 0), 0);
    checkOutput("f4Pixels", pixIdx, 12);
    checkOutput("f4LastHs", lastHs, 28);
    checkOutput("f4DoneCycle", doneCycle, 29);
    checkOutput("f4DoneCount", doneCount, 1);

    // Frame 5: reset in cycle 9 aborts the scan; no done, no further pixels.
    cyc = 0; pixIdx = 0; doneCount = 0; doneCycle = -1; checkTiming = 1'b1;
    applyStimulus(1, 1, 0);
    while (cyc < 9) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("abortValid", 32'(valid_out), 32'd0);
    checkOutput("abortBusy", 32'(busy_out), 32'd0);
    checkOutput("abortAddr", 32'(addr_out), 32'd0);
    checkOutput("abortPixels", pixIdx, 3);
    while (cyc < 30) applyStimulus(0, 1, 0);
    checkOutput("abortNoDone", doneCount, 0);
    checkOutput("abortNoPixels", pixIdx, 3);
    cyc = 0; pixIdx = 0; doneCount = 0; doneCycle = -1;
    applyStimulus(1, 1, 0);
    while (cyc < 25) applyStimulus(0, 1, 0);
    checkOutput("f5Pixels", pixIdx, 12);
    checkOutput("f5DoneCycle", doneCycle, 18);

    // Frame 6: start re-pulsed during SCAN and DRAIN must be ignored.
    cyc = 0; pixIdx = 0; doneCount = 0; doneCycle = -1;
    applyStimulus(1, 1, 0);
    while (cyc < 4) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    while (cyc < 15) applyStimulus(0, 1, 0);
    checkOutput("drainBusy", 32'(busy_out), 32'd1);
    applyStimulus(1, 1, 0);
    while (cyc < 40) applyStimulus(0, 1, 0);
    checkOutput("f6Pixels", pixIdx, 12);
    checkOutput("f6DoneCount", doneCount, 1);
    checkOutput("f6DoneCycle", doneCycle, 18);

    checkOutput("noOverflow", 32'(overflowSeen), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
